// File: rtl/iter_div.sv
// Radix-2 restoring divider, one quotient bit per clock, for the EX-stage divide handshake.
// Result is {remainder, quotient}; ready_o holds until the requester drops start_i.
module iter_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] acc;      // {rem[32:0], quo[31:0]}
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic        sign1, sign2;
  logic [31:0] mag1, mag2;
  logic [64:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    sign1   = signed_div_i & opdata1_i[31];
    sign2   = signed_div_i & opdata2_i[31];
    mag1    = sign1 ? (~opdata1_i + 32'd1) : opdata1_i;
    mag2    = sign2 ? (~opdata2_i + 32'd1) : opdata2_i;
    shifted = {acc[63:0], 1'b0};
    // rem < divisor keeps the true difference in (-2^32, 2^32), so bit 32 is the sign
    trial   = shifted[64:32] - {1'b0, dvsr};
    quo_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 6'd0;
      acc      <= 65'd0;
      dvsr     <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              acc   <= {33'd0, mag1};
              dvsr  <= mag2;
              neg_q <= sign1 ^ sign2;
              neg_r <= sign1;
              cnt   <= 6'd0;
            end
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else begin
            state    <= S_END;
            result_o <= 64'd0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else if (cnt == 6'd32) begin
            state    <= S_END;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end else begin
            if (!trial[32]) acc <= {trial, shifted[31:1], 1'b1};
            else            acc <= shifted;
            cnt <= cnt + 6'd1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_IDLE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed checks for iter_div: latency, signed/unsigned results, divide by zero,
// annul, reset mid-operation and operand stability after the start edge.
module tb_iter_div;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  iter_div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Start at a negedge; E0 is the next posedge. Optionally scramble operands after E0.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int exp_lat, input bit scramble);
    int n;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin
      signed_div_i = ~s; opdata1_i = 32'd7; opdata2_i = 32'd3;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready_o && n < 40);
    chk({tag, " lat"}, 64'(n), 64'(exp_lat));
    chk({tag, " res"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " rel_rdy"}, {63'd0, ready_o}, 64'd0);
    chk({tag, " rel_res"}, result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {63'd0, ready_o}, 64'd0);
    chk("rst_res", result_o, 64'd0);
    rst = 1'b0;

    run_div("u100_7",  1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33, 0);
    run_div("sm7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_div("s7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
    run_div("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7,        64'hFFFFFFFE_FFFFFFF2, 33, 0);
    run_div("smin_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
    run_div("umax_1",  1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, 0);
    run_div("u5_max",  1'b0, 32'd5,        32'hFFFFFFFF, 64'h00000005_00000000, 33, 0);
    run_div("stable",  1'b0, 32'd1000,     32'd10,       64'h00000000_00000064, 33, 1);

    // Divide by zero, start held five extra cycles
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'd1234; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("dz_rdy", {63'd0, ready_o}, 64'd1);
    chk("dz_res", result_o, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("dz_hold", {63'd0, ready_o}, 64'd1);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("dz_rel", {63'd0, ready_o}, 64'd0);

    // Annul at E10, ready must never rise
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd500; opdata2_i = 32'd4; start_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      chk("an_pre", {63'd0, ready_o}, 64'd0);
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    chk("an_e10", {63'd0, ready_o}, 64'd0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      chk("an_idle", {63'd0, ready_o}, 64'd0);
    end
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    // Reset at E20 with operand churn; block must not finish afterwards
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    opdata1_i = 32'd3; opdata2_i = 32'd0;
    for (int i = 1; i < 20; i++) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    chk("rs_rdy", {63'd0, ready_o}, 64'd0);
    chk("rs_res", result_o, 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("rs_idle", {63'd0, ready_o}, 64'd0);
    end
    run_div("post_rs", 1'b0, 32'd77, 32'd5, 64'h00000002_0000000F, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got none exp finish");
    $fatal(1);
  end
endmodule

// File: doc/iter_div.md
# iter_div

Iterative radix-2 restoring divider serving as the responder on the EX-stage divide handshake. It accepts two 32-bit operands with a start request and performs signed or unsigned division, one quotient bit per cycle. It returns `{remainder, quotient}` with a ready flag, and EX holds its stall request until that flag rises. EX owns `start_i`, `annul_i`, `signed_div_i` and the operands; this block owns the iteration state and the result.

## Interface
- No parameters. Operand width is fixed at 32 and result width at 64.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled only at the start edge.
- `opdata1_i`  in  32  dividend. Sampled only at the start edge.
- `opdata2_i`  in  32  divisor. Sampled only at the start edge.
- `start_i`  in  1  request. Held high by EX until it sees `ready_o`.
- `annul_i`  in  1  abort of an in-flight operation.
- `result_o`  out  64  `[63:32]` = remainder, `[31:0]` = quotient. Registered.
- `ready_o`  out  1  result valid. Registered.

## Operation
- The FSM has four states: IDLE, BYZERO, ON, END. Reset puts the block in IDLE with `result_o` = 0, `ready_o` = 0 and `cnt` = 0.
- **IDLE**
  - If `start_i` = 1 and `annul_i` = 0, and `opdata2_i` = 0: go to BYZERO.
  - If `start_i` = 1 and `annul_i` = 0, and `opdata2_i` ≠ 0: go to ON. Latch the magnitudes, latch the sign flags, and set `cnt` = 0.
  - Otherwise, stay in IDLE.
- **Magnitudes**
  - Signed mode: two's-complement negate any negative operand.
  - Unsigned mode: use the operands as-is.
  - Latch `neg_q` = sign1 XOR sign2 and `neg_r` = sign1. Both flags are 0 in unsigned mode.
- **ON**: datapath is a 65-bit register `{rem[32:0], quo[31:0]}`, initialised to `{33'b0, |dividend|}`.
  - Each edge: shift left 1, then compute trial = shifted `[64:32]` − `{1'b0, |divisor|}` (33-bit).
  - If trial ≥ 0: upper bits become trial and the LSB is set to 1. Otherwise the shifted value is kept, with LSB 0.
  - Each edge increments `cnt`.
  - When `cnt` = 32 at an edge, do no further iteration. Instead apply sign correction, load `result_o`, set `ready_o` = 1 and go to END.
- **Sign correction**
  - Quotient = `neg_q` ? −`quo` : `quo`.
  - Remainder = `neg_r` ? −`rem[31:0]` : `rem[31:0]`.
  - All arithmetic is modulo 2^32. As a result, 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
- **BYZERO**: on the next edge, load `result_o` = 0, set `ready_o` = 1 and go to END.
- **END**: hold `result_o` and `ready_o`. On an edge with `start_i` = 0, go to IDLE and clear `result_o` and `ready_o` to 0. While `start_i` stays 1, remain in END.
- **Annul**: `annul_i` = 1 in ON or BYZERO forces IDLE on that edge, with `ready_o` = 0, `result_o` = 0 and `cnt` = 0. `annul_i` is ignored in END.
- **Reset**: `rst` overrides everything, including mid-operation, and returns the block to reset values on that edge.
- **Operand stability**: changes on `opdata*_i` or `signed_div_i` after the start edge have no effect on the result.

## Timing
- Let E0 be the edge at which IDLE samples `start_i` = 1.
- **Normal operation**
  - Iterations occur at edges E1..E32.
  - `ready_o` and `result_o` become valid after E33. Latency is 33 cycles from E0.
  - Worst-case stall seen by EX is 34 cycles including the request cycle.
- **Divide by zero**: `ready_o` becomes valid after E1.
- **Release**
  - EX drops `start_i` in the cycle `ready_o` = 1, so `ready_o` normally lasts exactly one cycle.
  - The release edge is the same edge at which EX advances. The block is back in IDLE for the next cycle.
- **Back-to-back**: a second divide can present `start_i` in the cycle right after release. No bubble is required beyond that.
- **Output stability**: `result_o` and `ready_o` change only on clock edges. Neither has a combinational path from any input.

## Test plan
- Unsigned 100 / 7, start held until ready: `ready_o` rises exactly 33 edges after E0, with `result_o` = `{32'd2, 32'd14}`. After `start_i` drops, next cycle shows `ready_o` = 0 and `result_o` = 0.
- Signed −7 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Extremes:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Unsigned 0xFFFFFFFF / 1 gives quotient 0xFFFFFFFF, remainder 0.
  - Unsigned 5 / 0xFFFFFFFF gives quotient 0, remainder 5.
- Divide by zero (any dividend): `ready_o` = 1 after E1 with `result_o` = 0. Holding `start_i` high for 5 more cycles keeps `ready_o` = 1 and `result_o` = 0 until `start_i` drops.
- Pulse `annul_i` at E10: `ready_o` never asserts and the block returns to IDLE. A following unsigned 9 / 3 started next cycle returns `{0, 3}` after 33 edges.
- Assert `rst` at E20 with operand changes after E0: all outputs are 0 on the next edge. Separately, with no reset, changing operands after E0 leaves the result equal to the E0-sampled division.
